csa_reduce_sched: RTL and testbench
===================================

Name: csa_reduce_sched

Overview:
- Time-multiplexed multi-operand adder controller for the NTT datapath.
- Accepts a transaction of 1..MAX_OPS N-bit operands over a valid/ready stream and buffers them in a local register file.
- Repeatedly routes groups of CSA buffered words through one shared csa compressor (CSA:3) until 3 or fewer words remain, then performs a final carry-propagate add.
- Returns the sum mod 2^N on an output valid/ready port; sits between the operand generators and the modular reduction unit.

Parameters:
- N, 64, operand/result width in bits
- CSA, 6, compressor input count; legal range 5..8 (compressor always yields 3 words)
- MAX_OPS, 36, maximum operands per transaction; buffer depth
- CW, $clog2(MAX_OPS+1), width of the operand count

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin transaction; accepted only when start_ready=1
- op_count  input  CW  operands in this transaction; sampled with start
- start_ready  output  1  high only in IDLE
- in_valid  input  1  operand valid
- in_data  input  N  operand
- in_ready  output  1  high only in LOAD
- out_valid  output  1  result valid
- out_data  output  N  result, sum of all operands mod 2^N
- out_ready  input  1  result consumed
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values, applied asynchronously: state=IDLE, start_ready=1, in_ready=0, out_valid=0, out_data=0, busy=0. Count registers are cleared; buffer contents are don't-care. Reset mid-transaction abandons it with no output.
- FSM states: IDLE, LOAD, REDUCE, FINAL, OUT.
- IDLE:
  - start=1 with op_count=0 -> OUT with out_data=0.
  - start=1 with op_count>MAX_OPS -> clamp to MAX_OPS.
  - otherwise -> LOAD; latch remaining=op_count and cnt=0.
- LOAD:
  - Each in_valid&in_ready handshake writes buf[cnt]=in_data, cnt++, remaining--.
  - After the last operand: -> REDUCE if cnt>3, else -> FINAL.
  - in_valid low stalls with no timeout.
  - start is ignored in every non-IDLE state.
- REDUCE, one compressor pass per cycle:
  - k=min(cnt,CSA). Compressor inputs are buf[cnt-k..cnt-1]; unused inputs are forced to 0.
  - The 3 outputs are registered into buf[cnt-k..cnt-k+2], and cnt becomes cnt-k+3.
  - Stay in REDUCE while the new cnt>3; otherwise -> FINAL.
  - Pass count for cnt>3 is ceil((cnt-3)/(CSA-3)). With CSA=6: 36 operands take 11 passes; 4 or 5 operands take 1.
- FINAL, one cycle:
  - out_data <= buf[0]+buf[1]+buf[2] mod 2^N, with entries at index >= cnt treated as 0.
  - -> OUT with out_valid=1.
- OUT:
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid=0, -> IDLE. start_ready rises the cycle after.
  - No back-to-back overlap.
- Latency from last operand handshake to out_valid: R+1 cycles, where R is the REDUCE pass count. The op_count=0 case reaches out_valid 1 cycle after start.
- Arithmetic:
  - All sums are modulo 2^N and carries out of bit N-1 are discarded, in both the compressor and the final add.
  - The compressor's 3 outputs must sum (mod 2^N) to the sum of its inputs.
- Simultaneous events:
  - In IDLE, start is accepted regardless of in_valid.
  - In OUT, in_valid is ignored (in_ready=0).

Decomposition:
- Shared package holds:
  - the FSM state enum (sched_state_t);
  - the CW width function;
  - the constant CSA_OUTS=3;
  - the pass-count function used by both RTL assertions and the bench.
- One sub-module: the existing csa compressor with N and CSA parameters, instantiated once and combinational. Buffer, FSM, counters and the final adder stay in csa_reduce_sched.

Test Plan:
- op_count=1, operand 0x5 -> out_data=0x5, 0 REDUCE cycles, out_valid 1 cycle after the handshake.
- op_count=6, operands 1..6 -> out_data=21, exactly 1 REDUCE cycle, out_valid 2 cycles after the last handshake.
- op_count=36, all operands 2^64-1 -> out_data=2^64-36 (wrap check), 11 REDUCE cycles.
- op_count=0 -> out_data=0 and out_valid=1 one cycle after start; in_ready never asserted.
- op_count=5 with random in_valid gaps and out_ready held low 10 cycles -> out_data stable throughout; start ignored while busy; correct sum.
- Assert rst mid-REDUCE with op_count=20 -> all outputs return to reset values immediately; next transaction of 3 operands 7, 8, 9 -> out_data=24.

Source files
------------

// File: rtl/csa_reduce_sched_pkg.sv
// Shared types and helpers for the multi-operand CSA reduction scheduler.
// Holds the FSM encoding, the count-width rule and the compressor pass-count formula.
package csa_reduce_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        REDUCE = 3'd2,
        FINAL  = 3'd3,
        OUT    = 3'd4
    } sched_state_t;

    localparam int CSA_OUTS = 3;

    function automatic int cw_width(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

    // Compressor passes needed to bring cnt words down to CSA_OUTS or fewer.
    function automatic int pass_count(input int cnt, input int csa);
        if (cnt <= CSA_OUTS) return 0;
        return (cnt - CSA_OUTS + (csa - CSA_OUTS) - 1) / (csa - CSA_OUTS);
    endfunction

endpackage

// File: rtl/csa_reduce_sched_csa.sv
// Combinational CSA compressor: CSA words in, 3 words out with the same sum mod 2^N.
// Built as a chain of 3:2 carry-save stages; carries out of bit N-1 are dropped.
module csa_reduce_sched_csa
    import csa_reduce_sched_pkg::*;
#(
    parameter int N   = 64,
    parameter int CSA = 6
) (
    input  logic [CSA-1:0][N-1:0]      in_words,
    output logic [CSA_OUTS-1:0][N-1:0] out_words
);

    logic [CSA-1:0][N-1:0] w;
    logic [N-1:0]          a, b, c, maj;

    // Stage i folds w[i..i+2] into w[i+1..i+2]; the live window slides up by one.
    always_comb begin
        w   = in_words;
        a   = '0;
        b   = '0;
        c   = '0;
        maj = '0;
        for (int i = 0; i < CSA - CSA_OUTS; i++) begin
            a        = w[i];
            b        = w[i+1];
            c        = w[i+2];
            maj      = (a & b) | (a & c) | (b & c);
            w[i+1]   = a ^ b ^ c;
            w[i+2]   = {maj[N-2:0], 1'b0};
        end
        out_words = w[CSA-1 -: CSA_OUTS];
    end

endmodule

// File: rtl/csa_reduce_sched.sv
// Time-multiplexed multi-operand adder: buffers a transaction of operands, folds them
// through one shared CSA compressor until 3 words remain, then does a final add.
module csa_reduce_sched
    import csa_reduce_sched_pkg::*;
#(
    parameter int N       = 64,
    parameter int CSA     = 6,
    parameter int MAX_OPS = 36,
    parameter int CW      = cw_width(MAX_OPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] op_count,
    output logic          start_ready,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic          busy,
    output sched_state_t  state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high; start/start_ready, in_valid/in_ready and out_valid/out_ready alike.

    sched_state_t state, state_next;

    logic [CW-1:0] cnt, remaining;
    logic [N-1:0]  op_buf [MAX_OPS];

    logic [CW-1:0] k, base, cnt_reduced;
    logic [CSA-1:0][N-1:0]      csa_in;
    logic [CSA_OUTS-1:0][N-1:0] csa_out;
    logic [N-1:0]  final_sum;
    logic          load_hs;

    assign start_ready = (state == IDLE);
    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == OUT);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;
    assign load_hs     = in_ready && in_valid;

    // Each pass consumes the top k words and writes 3 back in their place.
    assign k           = (cnt < CW'(CSA)) ? cnt : CW'(CSA);
    assign base        = cnt - k;
    assign cnt_reduced = base + CW'(CSA_OUTS);

    always_comb begin
        csa_in = '0;
        for (int j = 0; j < CSA; j++)
            if (CW'(j) < k) csa_in[j] = op_buf[base + CW'(j)];
    end

    csa_reduce_sched_csa #(.N(N), .CSA(CSA)) u_csa (
        .in_words  (csa_in),
        .out_words (csa_out)
    );

    always_comb begin
        final_sum = '0;
        for (int i = 0; i < CSA_OUTS; i++)
            if (CW'(i) < cnt) final_sum = final_sum + op_buf[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = (op_count == '0) ? OUT : LOAD;
            LOAD:   if (load_hs && remaining == CW'(1))
                        state_next = (cnt >= CW'(CSA_OUTS)) ? REDUCE : FINAL;
            REDUCE: if (cnt_reduced <= CW'(CSA_OUTS)) state_next = FINAL;
            FINAL:  state_next = OUT;
            OUT:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            remaining <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt       <= '0;
                    remaining <= (op_count > CW'(MAX_OPS)) ? CW'(MAX_OPS) : op_count;
                    if (op_count == '0) out_data <= '0;
                end
                LOAD: if (load_hs) begin
                    cnt       <= cnt + CW'(1);
                    remaining <= remaining - CW'(1);
                end
                REDUCE: cnt      <= cnt_reduced;
                FINAL:  out_data <= final_sum;
                default: ;
            endcase
        end
    end

    // Operand storage carries no reset; stale entries are masked by cnt.
    always_ff @(posedge clk) begin
        if (load_hs)
            op_buf[cnt] <= in_data;
        else if (state == REDUCE)
            for (int i = 0; i < CSA_OUTS; i++)
                op_buf[base + CW'(i)] <= csa_out[i];
    end

    always_ff @(posedge clk) begin
        if (!rst && state == REDUCE)
            assert (pass_count(int'(cnt_reduced), CSA) + 1 == pass_count(int'(cnt), CSA))
                else $error("reduce pass did not shrink the word count by one pass");
    end

endmodule

// File: tb/tb_csa_reduce_sched.sv
// Self-checking bench for csa_reduce_sched: vector table, random transactions against a
// sum-of-operands model, and hand-written backpressure and mid-reduce reset sequences.
module tb_csa_reduce_sched;
    import csa_reduce_sched_pkg::*;

    localparam int N       = 64;
    localparam int CSA     = 6;
    localparam int MAX_OPS = 36;
    localparam int CW      = cw_width(MAX_OPS);

    localparam int P_SEQ   = 0;
    localparam int P_ONES  = 1;
    localparam int P_FIVE  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] op_count;
    logic          start_ready;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic          busy;
    sched_state_t  state_dbg;

    csa_reduce_sched #(.N(N), .CSA(CSA), .MAX_OPS(MAX_OPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_count    (op_count),
        .start_ready (start_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] exp_q [$];
    logic [N-1:0] ops [MAX_OPS + 8];

    typedef struct {
        int           count;
        int           pattern;
        logic [N-1:0] exp_sum;
        int           exp_red;
        int           exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_and_finish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on the DUT", name);
        report_and_finish();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start_ready"}, N'(start_ready), N'(1));
        check({tag, "_in_ready"},    N'(in_ready),    N'(0));
        check({tag, "_out_valid"},   N'(out_valid),   N'(0));
        check({tag, "_out_data"},    out_data,        N'(0));
        check({tag, "_busy"},        N'(busy),        N'(0));
    endtask

    // ---------------- driver tasks ----------------
    // Issues start, then streams min(count, MAX_OPS) operands from ops[]; pushes the
    // model sum to the scoreboard. Returns one tick after the last handshake edge.
    task automatic send_txn(input int count, input int gap_max, input bit poke_start);
        int eff;
        int guard;
        logic [N-1:0] sum;
        eff = (count > MAX_OPS) ? MAX_OPS : count;
        sum = '0;
        for (int i = 0; i < eff; i++) sum = sum + ops[i];
        exp_q.push_back(sum);

        guard = 0;
        while (!start_ready && guard < 200) begin tick(); guard++; end
        if (!start_ready) timeout("start_ready_wait");
        start    = 1'b1;
        op_count = CW'(count);
        tick();
        start    = 1'b0;
        if (count == 0) return;

        for (int i = 0; i < eff; i++) begin
            int gaps;
            gaps     = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            in_valid = 1'b0;
            for (int g = 0; g < gaps; g++) begin
                start    = poke_start;
                op_count = CW'(3);
                tick();
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = ops[i];
            guard    = 0;
            while (!in_ready && guard < 100) begin tick(); guard++; end
            if (!in_ready) timeout("in_ready_wait");
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Waits for out_valid counting REDUCE cycles, holds out_ready low for hold cycles,
    // then consumes the result and checks it against the scoreboard.
    task automatic collect_txn(input int count, input int hold, input bit poke_start,
                               output int red, output int lat, output logic [N-1:0] got);
        logic [N-1:0] held;
        logic [N-1:0] exp;
        red = 0;
        lat = (count == 0) ? 1 : 0;
        while (!out_valid && lat < 200) begin
            if (state_dbg == REDUCE) red++;
            tick();
            lat++;
        end
        if (!out_valid) timeout("out_valid_wait");

        held = out_data;
        for (int h = 0; h < hold; h++) begin
            start    = poke_start;
            op_count = CW'(3);
            tick();
            check("hold_out_valid", N'(out_valid), N'(1));
            check("hold_out_data",  out_data,      held);
        end
        start = 1'b0;

        got = out_data;
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", N'(0), N'(1));
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("out_data_vs_model", got, exp);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid",   N'(out_valid),   N'(0));
        check("post_start_ready", N'(start_ready), N'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs [8];
        int red, lat;
        logic [N-1:0] got;

        vecs[0] = '{count: 1,  pattern: P_FIVE, exp_sum: 64'h5,              exp_red: 0,  exp_lat: 1};
        vecs[1] = '{count: 6,  pattern: P_SEQ,  exp_sum: 64'd21,             exp_red: 1,  exp_lat: 2};
        vecs[2] = '{count: 36, pattern: P_ONES, exp_sum: 64'hFFFF_FFFF_FFFF_FFDC, exp_red: 11, exp_lat: 12};
        vecs[3] = '{count: 0,  pattern: P_SEQ,  exp_sum: 64'd0,              exp_red: 0,  exp_lat: 1};
        vecs[4] = '{count: 4,  pattern: P_SEQ,  exp_sum: 64'd10,             exp_red: 1,  exp_lat: 2};
        vecs[5] = '{count: 3,  pattern: P_SEQ,  exp_sum: 64'd6,              exp_red: 0,  exp_lat: 1};
        vecs[6] = '{count: 40, pattern: P_SEQ,  exp_sum: 64'd666,            exp_red: 11, exp_lat: 12};
        vecs[7] = '{count: 7,  pattern: P_SEQ,  exp_sum: 64'd28,             exp_red: 2,  exp_lat: 3};

        rst       = 1'b1;
        start     = 1'b0;
        op_count  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Table-driven vectors
        foreach (vecs[v]) begin
            for (int i = 0; i < MAX_OPS + 8; i++) begin
                case (vecs[v].pattern)
                    P_ONES:  ops[i] = '1;
                    P_FIVE:  ops[i] = 64'h5;
                    default: ops[i] = N'(i + 1);
                endcase
            end
            send_txn(vecs[v].count, 0, 1'b0);
            if (vecs[v].count == 0) check("zero_in_ready", N'(in_ready), N'(0));
            collect_txn(vecs[v].count, 0, 1'b0, red, lat, got);
            check($sformatf("vec%0d_sum", v), got,        vecs[v].exp_sum);
            check($sformatf("vec%0d_red", v), N'(red),    N'(vecs[v].exp_red));
            check($sformatf("vec%0d_lat", v), N'(lat),    N'(vecs[v].exp_lat));
        end

        // op_count=5 with input gaps, output stalled 10 cycles, start poked while busy
        for (int i = 0; i < 5; i++) ops[i] = {$urandom, $urandom};
        send_txn(5, 3, 1'b1);
        collect_txn(5, 10, 1'b1, red, lat, got);
        check("stall5_red", N'(red), N'(1));
        check("stall5_lat", N'(lat), N'(2));

        // Reset while reducing abandons the transaction
        for (int i = 0; i < 20; i++) ops[i] = {$urandom, $urandom};
        send_txn(20, 0, 1'b0);
        check("mid_reduce_state", N'(state_dbg == REDUCE), N'(1));
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        ops[0] = 64'd7;
        ops[1] = 64'd8;
        ops[2] = 64'd9;
        send_txn(3, 0, 1'b0);
        collect_txn(3, 0, 1'b0, red, lat, got);
        check("after_reset_sum", got, 64'd24);

        // Randomized transactions against the sum model
        for (int t = 0; t < 25; t++) begin
            int cnt;
            int eff;
            cnt = $urandom_range(0, MAX_OPS + 2);
            eff = (cnt > MAX_OPS) ? MAX_OPS : cnt;
            for (int i = 0; i < MAX_OPS + 8; i++) ops[i] = {$urandom, $urandom};
            send_txn(cnt, $urandom_range(0, 2), 1'b0);
            collect_txn(cnt, $urandom_range(0, 3), 1'b0, red, lat, got);
            check($sformatf("rand%0d_red", t), N'(red), N'(pass_count(eff, CSA)));
            check($sformatf("rand%0d_lat", t), N'(lat),
                  N'((cnt == 0) ? 1 : pass_count(eff, CSA) + 1));
        end

        check("scoreboard_drained", N'(exp_q.size()), N'(0));
        report_and_finish();
    end

    initial begin
        #2_000_000;
        timeout("global_time_limit");
    end

endmodule
